// File: rtl/fa_bist_pkg.sv
// -----------------------------------------------------------------------------
// fa_bist_pkg
// Shared types and constants for the full-adder BIST controller.
//   state_t     : controller FSM states
//   NUM_VECTORS : number of exhaustive input vectors for a 1-bit full adder
//   IDX_W       : vector index width
//   CNT_W       : error / settle counter width
// -----------------------------------------------------------------------------
package fa_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/fa_bist_golden.sv
// -----------------------------------------------------------------------------
// fa_golden
// Combinational 1-bit full-adder reference model. The vector index is
// interpreted as {a, b, cin}; the outputs are the expected adder results.
//   i_idx      : {a, b, cin}
//   o_exp_sum  : expected sum
//   o_exp_cout : expected carry out
// -----------------------------------------------------------------------------
module fa_golden
  import fa_bist_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_exp_sum,
  output logic             o_exp_cout
);

  logic [1:0] w_total;

  assign w_total    = {1'b0, i_idx[2]} + {1'b0, i_idx[1]} + {1'b0, i_idx[0]};
  assign o_exp_sum  = w_total[0];
  assign o_exp_cout = w_total[1];

endmodule

// File: rtl/full_adder_bist.sv
// -----------------------------------------------------------------------------
// full_adder_bist
// Built-in self-test controller for a 1-bit full adder. On start it walks the
// eight input vectors {a,b,cin} = 0..7, waits SETTLE_CYCLES after applying
// each one, and compares the adder outputs against fa_golden.
//
// Optional feature macro: FA_BIST_STOP_ON_FAIL_EN
//   defined     : first mismatch ends the run immediately (err_count = 1)
//   not defined : all eight vectors run and every mismatch is counted
//
// Ports
//   i_clk         : system clock, rising edge
//   i_rst         : asynchronous active-high reset
//   i_start       : single-cycle run request, honoured in IDLE or DONE only
//   o_a/o_b/o_cin : stimulus to the adder under test
//   i_sum/i_cout  : adder outputs, sampled in CHECK
//   o_busy        : high from APPLY through CHECK of the last vector
//   o_done        : level, high in DONE until next accepted start or reset
//   o_pass        : done with zero errors
//   o_err_count   : mismatching vectors in the current run (0..8)
//   o_fail_vec    : index of first mismatching vector
//
// States
//   S_IDLE  | waiting for start, stimulus forced to 0
//   S_APPLY | vector driven, one cycle
//   S_WAIT  | settle time, SETTLE_CYCLES cycles
//   S_CHECK | compare adder outputs against golden model, one cycle
//   S_DONE  | results valid, last vector held, waiting for restart
// -----------------------------------------------------------------------------
module full_adder_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_a,
  output logic             o_b,
  output logic             o_cin,
  input  logic             i_sum,
  input  logic             i_cout,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_count,
  output logic [IDX_W-1:0] o_fail_vec
);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_stim;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [CNT_W-1:0] r_err_count;
  logic [IDX_W-1:0] r_fail_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_exp_sum;
  logic             w_exp_cout;
  logic             w_mismatch;
  logic             w_last;
  logic             w_stop;

  fa_golden u_golden (
    .i_idx      (r_idx),
    .o_exp_sum  (w_exp_sum),
    .o_exp_cout (w_exp_cout)
  );

  assign w_mismatch = (i_sum != w_exp_sum) || (i_cout != w_exp_cout);
  assign w_last     = (r_idx == IDX_W'(NUM_VECTORS - 1));

`ifdef FA_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_stim       <= '0;
      r_settle_cnt <= '0;
      r_err_count  <= '0;
      r_fail_vec   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_APPLY;
            r_idx       <= '0;
            r_stim      <= '0;
            r_err_count <= '0;
            r_fail_vec  <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end

        S_APPLY: begin
          r_state      <= S_WAIT;
          r_settle_cnt <= '0;
        end

        S_WAIT: begin
          if (r_settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_state <= S_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
          end
        end

        S_CHECK: begin
          if (w_mismatch) begin
            r_err_count <= r_err_count + CNT_W'(1);
            if (r_err_count == '0) begin
              r_fail_vec <= r_idx;
            end
          end
          if (w_last || w_stop) begin
            // Stimulus (r_stim) intentionally left holding the last vector.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !w_mismatch && (r_err_count == '0);
          end else begin
            r_state <= S_APPLY;
            r_idx   <= r_idx + IDX_W'(1);
            r_stim  <= r_idx + IDX_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
          r_stim  <= '0;
        end
      endcase
    end
  end

  assign {o_a, o_b, o_cin} = r_stim;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_pass            = r_pass;
  assign o_err_count       = r_err_count;
  assign o_fail_vec        = r_fail_vec;

endmodule

// File: tb/tb_full_adder_bist.sv
// -----------------------------------------------------------------------------
// tb_full_adder_bist
// Self-checking bench for full_adder_bist with a behavioural adder that can be
// made faulty (cout stuck at 0, or sum inverted).
// -----------------------------------------------------------------------------
module tb_full_adder_bist;
  import fa_bist_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             a, b, cin;
  logic             sum, cout;
  logic             busy, done, pass;
  logic [CNT_W-1:0] err_count;
  logic [IDX_W-1:0] fail_vec;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;   // 0 good, 1 cout stuck 0, 2 sum inverted

  always #5 clk = ~clk;

  full_adder_bist #(.SETTLE_CYCLES(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .o_a         (a),
    .o_b         (b),
    .o_cin       (cin),
    .i_sum       (sum),
    .i_cout      (cout),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_err_count (err_count),
    .o_fail_vec  (fail_vec)
  );

  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
    if (fault_mode == 1) cout = 1'b0;
    if (fault_mode == 2) sum  = ~(a ^ b ^ cin);
  end

  typedef struct {
    int mode;
    int exp_cycles;
    int exp_err;
    int exp_fail;
    int exp_pass;
    int exp_stim;
  } vec_t;

  vec_t tbl [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int outs_or();
    return int'(a | b | cin | busy | done | pass) + int'(err_count) + int'(fail_vec);
  endfunction

  // Accept a start (edge 0) and wait for done, checking stimulus every cycle.
  task automatic run(input int mode, output int cycles);
    fault_mode = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    chk("accept_busy", int'(busy), 1);
    chk("accept_stim", int'({a, b, cin}), 0);
    while (!done && cycles < 100) begin
      tick();
      cycles++;
      if (!done) chk($sformatf("stim_c%0d", cycles), int'({a, b, cin}), cycles / 4);
    end
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;

`ifdef FA_BIST_STOP_ON_FAIL_EN
    tbl[0] = '{0, 32, 0, 0, 1, 7};
    tbl[1] = '{1, 16, 1, 3, 0, 3};
    tbl[2] = '{2,  4, 1, 0, 0, 0};
`else
    tbl[0] = '{0, 32, 0, 0, 1, 7};
    tbl[1] = '{1, 32, 4, 3, 0, 7};
    tbl[2] = '{2, 32, 8, 0, 0, 7};
`endif

    tick();
    tick();
    chk("reset_outputs", outs_or(), 0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", outs_or(), 0);

    foreach (tbl[i]) begin
      run(tbl[i].mode, cyc);
      chk($sformatf("m%0d_cycles", tbl[i].mode), cyc, tbl[i].exp_cycles);
      chk($sformatf("m%0d_done", tbl[i].mode), int'(done), 1);
      chk($sformatf("m%0d_busy", tbl[i].mode), int'(busy), 0);
      chk($sformatf("m%0d_err", tbl[i].mode), int'(err_count), tbl[i].exp_err);
      chk($sformatf("m%0d_fail_vec", tbl[i].mode), int'(fail_vec), tbl[i].exp_fail);
      chk($sformatf("m%0d_pass", tbl[i].mode), int'(pass), tbl[i].exp_pass);
      chk($sformatf("m%0d_stim_hold", tbl[i].mode), int'({a, b, cin}), tbl[i].exp_stim);
      tick();
      chk($sformatf("m%0d_done_level", tbl[i].mode), int'(done), 1);
    end

    // start pulsed at cycle 10 of a run must be ignored
    fault_mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      if (cyc == 10) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
      if (cyc == 11) chk("ign_start_stim", int'({a, b, cin}), 2);
    end
    chk("ign_start_cycles", cyc, 32);
    chk("ign_start_pass", int'(pass), 1);

    // restart from DONE after a failing run clears results
    run(1, cyc);
    chk("pre_restart_err", int'(err_count), tbl[1].exp_err);
    fault_mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_err", int'(err_count), 0);
    chk("restart_fail_vec", int'(fail_vec), 0);
    chk("restart_pass", int'(pass), 0);
    chk("restart_stim", int'({a, b, cin}), 0);
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("restart_cycles", cyc, 32);
    chk("restart_final_pass", int'(pass), 1);

    // reset mid-run at cycle 12 (mode 2 so err_count is non-zero by then)
    fault_mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("pre_rst_err", int'(err_count), 3);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", outs_or(), 0);
    tick();
    chk("rst_edge_outputs", outs_or(), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("rst_stays_idle", outs_or(), 0);
    run(0, cyc);
    chk("post_rst_cycles", cyc, 32);
    chk("post_rst_pass", int'(pass), 1);
    chk("post_rst_err", int'(err_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
